// File: rtl/hps_handshake_bridge.sv
// Bridges an HPS PIO 4-phase req/ack handshake to fabric valid/ready streams.
// One request word goes out on rx_*, one response word comes back on tx_*.
module hps_handshake_bridge #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [16:0] hps_out,
    output logic [16:0] hps_in,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [15:0] txn_count,
    output logic        timeout_flag,
    output logic        proto_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Handshake: rx word transfers on rx_valid & rx_ready, tx word on tx_valid & tx_ready.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        RESPOND = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   ack;
    logic [15:0]            response;
    logic [TW-1:0]          timer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_sync <= '0;
        end else begin
            req_sync[0] <= hps_out[16];
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req_sync[i] <= req_sync[i-1];
            end
        end
    end

    assign req_s    = req_sync[SYNC_STAGES-1];
    assign tx_ready = (state == RESPOND);
    assign hps_in   = {ack, response};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ack          <= 1'b0;
            response     <= 16'h0000;
            rx_data      <= 16'h0000;
            rx_valid     <= 1'b0;
            txn_count    <= 16'h0000;
            timeout_flag <= 1'b0;
            proto_err    <= 1'b0;
            timer        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= 1'b0;
                    // Data bits are stable whenever the synchronised req is high.
                    if (req_s) begin
                        rx_data  <= hps_out[15:0];
                        rx_valid <= 1'b1;
                        state    <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (rx_valid && rx_ready) begin
                        rx_valid <= 1'b0;
                        timer    <= '0;
                        state    <= RESPOND;
                    end
                end
                RESPOND: begin
                    // Fabric data beats both an abort and the timeout.
                    if (tx_valid) begin
                        response <= tx_data;
                        ack      <= 1'b1;
                        state    <= ACK;
                    end else if (!req_s) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        response     <= 16'hFFFF;
                        timeout_flag <= 1'b1;
                        ack          <= 1'b1;
                        state        <= ACK;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        ack       <= 1'b0;
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hps_handshake_bridge.sv
// Directed bench for hps_handshake_bridge with SYNC_STAGES=2, TIMEOUT_CYCLES=16.
// Table of complete transactions plus hand-written timeout/abort/wrap/reset sequences.
module tb_hps_handshake_bridge;

    logic        clk;
    logic        reset;
    logic [16:0] hps_out;
    logic [16:0] hps_in;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] txn_count;
    logic        timeout_flag;
    logic        proto_err;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] req_word;
        logic [15:0] rsp_word;
        logic [15:0] exp_rx;
        logic [16:0] exp_hps_in;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[4];

    hps_handshake_bridge #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hps_out     (hps_out),
        .hps_in      (hps_in),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .txn_count   (txn_count),
        .timeout_flag(timeout_flag),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Raise req with a word; rx_valid must appear exactly three cycles later.
    task automatic start_req(input logic [15:0] word, input logic [15:0] exp_rx);
        rx_ready = 1'b0;
        hps_out  = {1'b1, word};
        tick();
        tick();
        check("rx_valid_early", rx_valid, 1'b0);
        tick();
        check("rx_valid_rise", rx_valid, 1'b1);
        check("rx_data", rx_data, exp_rx);
    endtask

    task automatic enter_respond();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("tx_ready_respond", tx_ready, 1'b1);
        check("rx_valid_drop", rx_valid, 1'b0);
    endtask

    task automatic send_rsp(input logic [15:0] word);
        tx_data  = word;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx_ready_after", tx_ready, 1'b0);
    endtask

    // Drop req; ack must hold for two cycles and fall on the third.
    task automatic finish_ack(input logic [15:0] exp_word, input logic [15:0] exp_count);
        hps_out[16] = 1'b0;
        tick();
        tick();
        check("ack_hold", hps_in[16], 1'b1);
        tick();
        check("ack_fall", hps_in, {1'b0, exp_word});
        check("txn_count", txn_count, exp_count);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'hBEEF, 16'h1234, 17'h1_BEEF, 16'd1};
        vecs[1] = '{16'h0000, 16'hFFFE, 16'h0000, 17'h1_FFFE, 16'd2};
        vecs[2] = '{16'hA5A5, 16'h0000, 16'hA5A5, 17'h1_0000, 16'd3};
        vecs[3] = '{16'hFFFF, 16'h5A5A, 16'hFFFF, 17'h1_5A5A, 16'd4};

        reset    = 1'b1;
        hps_out  = 17'h0;
        rx_ready = 1'b0;
        tx_data  = 16'h0;
        tx_valid = 1'b0;
        tick();
        tick();
        check("rst_hps_in", hps_in, 17'h0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 16'h0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_txn_count", txn_count, 16'h0);
        check("rst_timeout", timeout_flag, 1'b0);
        check("rst_proto_err", proto_err, 1'b0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            start_req(vecs[i].req_word, vecs[i].exp_rx);
            enter_respond();
            send_rsp(vecs[i].rsp_word);
            check("ack_rise", hps_in, vecs[i].exp_hps_in);
            finish_ack(vecs[i].exp_hps_in[15:0], vecs[i].exp_count);
        end

        // tx_valid arrives on the 16th RESPOND cycle, same cycle as the timer expiry.
        start_req(16'h7777, 16'h7777);
        enter_respond();
        for (int k = 0; k < 15; k++) begin
            tick();
            check("coin_wait", {tx_ready, hps_in[16]}, 2'b10);
        end
        send_rsp(16'h0042);
        check("coin_hps_in", hps_in, 17'h1_0042);
        check("coin_timeout_flag", timeout_flag, 1'b0);
        finish_ack(16'h0042, 16'd5);

        // Backpressure in DELIVER, then a full timeout.
        start_req(16'hCAFE, 16'hCAFE);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold", {tx_ready, rx_valid, rx_data}, {2'b01, 16'hCAFE});
        end
        enter_respond();
        for (int k = 0; k < 15; k++) begin
            tick();
            check("to_wait", {tx_ready, hps_in[16]}, 2'b10);
        end
        tick();
        check("to_hps_in", hps_in, 17'h1_FFFF);
        check("to_flag", timeout_flag, 1'b1);
        finish_ack(16'hFFFF, 16'd6);

        // HPS drops req while the bridge waits for the fabric.
        start_req(16'h1357, 16'h1357);
        enter_respond();
        hps_out[16] = 1'b0;
        tick();
        tick();
        check("abort_early", proto_err, 1'b0);
        tick();
        check("abort_proto_err", proto_err, 1'b1);
        check("abort_tx_ready", tx_ready, 1'b0);
        tick();
        tick();
        check("abort_no_ack", hps_in, 17'h0_FFFF);
        check("abort_no_count", txn_count, 16'd6);

        // Preload the counter to its top value, then complete one transaction.
        dut.txn_count = 16'hFFFF;
        tick();
        start_req(16'h2468, 16'h2468);
        enter_respond();
        send_rsp(16'h1111);
        check("wrap_ack", hps_in, 17'h1_1111);
        finish_ack(16'h1111, 16'h0000);

        // Reset in ACK with req still high; restart once the synchroniser refills.
        start_req(16'h9999, 16'h9999);
        enter_respond();
        send_rsp(16'hABCD);
        check("mid_ack_hps_in", hps_in, 17'h1_ABCD);
        check("sticky_flags", {timeout_flag, proto_err}, 2'b11);
        reset = 1'b1;
        #1;
        check("rst_ack_hps_in", hps_in, 17'h0);
        check("rst_ack_flags", {timeout_flag, proto_err}, 2'b00);
        check("rst_ack_count", txn_count, 16'h0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("restart_early", rx_valid, 1'b0);
        tick();
        check("restart_rx_valid", rx_valid, 1'b1);
        check("restart_rx_data", rx_data, 16'h9999);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hps_handshake_bridge.md
HPS_HANDSHAKE_BRIDGE -- requirements
Module: hps_handshake_bridge

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL provide parameter SYNC_STAGES, default 2, the number of synchroniser flops on hps_out[16] (minimum 1).
REQ-003 The block SHALL provide parameter TIMEOUT_CYCLES, default 1024, the number of RESPOND cycles before a timeout response is generated (minimum 2).
REQ-004 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  async active-high reset
- hps_out  in  17  from HPS PIO out_port; [16]=req, [15:0]=request word
- hps_in  out  17  to HPS PIO in_port; [16]=ack, [15:0]=response word
- rx_data  out  16  request word to fabric
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  fabric accepts rx_data
- tx_data  in  16  response word from fabric
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  bridge accepts tx_data
- txn_count  out  16  completed transactions, wraps 0xFFFF->0x0000
- timeout_flag  out  1  sticky, a timeout response was sent
- proto_err  out  1  sticky, HPS dropped req before ack

Function
REQ-005 The block SHALL pass hps_out[16] through SYNC_STAGES flops to form req_s; hps_out[15:0] SHALL be sampled unsynchronised, since the HPS holds it stable while req=1.
REQ-006 The block SHALL implement FSM states IDLE, DELIVER, RESPOND, ACK.
REQ-007 IDLE: ack=0; when req_s=1, capture hps_out[15:0] into rx_data, set rx_valid=1, and go to DELIVER.
REQ-008 rx_valid SHALL rise SYNC_STAGES+1 cycles after hps_out[16] rises.
REQ-009 DELIVER: rx_valid and rx_data SHALL stay stable until a cycle with rx_valid&rx_ready; then rx_valid<=0, timer<=0, and go to RESPOND.
REQ-010 req_s is ignored in DELIVER.
REQ-011 RESPOND: tx_ready=1 (combinational from state); tx_ready SHALL be 0 in all other states.
REQ-012 RESPOND, tx_valid=1: latch tx_data into the response register and go to ACK.
REQ-013 RESPOND, no tx_valid, timer=TIMEOUT_CYCLES-1: response<=16'hFFFF, timeout_flag<=1, go to ACK; otherwise timer increments.
REQ-014 If tx_valid and timer expiry coincide, tx_valid SHALL win: the fabric data is used and no flag is set.
REQ-015 RESPOND, req_s=0 with no tx_valid: proto_err<=1, return to IDLE, no ack and no count; tx_valid has priority over req_s=0.
REQ-016 ACK: hps_in[16]=1 (registered), hps_in[15:0]=response; when req_s=0, drop ack, txn_count<=txn_count+1, and return to IDLE.
REQ-017 ack SHALL rise on the cycle after the accepting tx_valid&tx_ready cycle.
REQ-018 ack SHALL fall SYNC_STAGES+1 cycles after hps_out[16] falls.
REQ-019 hps_in[15:0] SHALL hold the last response value outside ACK.
REQ-020 A new request SHALL be accepted only after returning to IDLE, which guarantees the 4-phase req/ack ordering.
REQ-021 timeout_flag and proto_err SHALL clear only on reset.

Reset
REQ-022 While reset=1, the block SHALL force: state IDLE; hps_in=0; rx_data=0; rx_valid=0; txn_count=0; timeout_flag=0; proto_err=0; timer=0; synchroniser=0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction immediately with ack=0 and no count.
REQ-024 After reset release, if hps_out[16] is already 1, the block SHALL start a transaction after the synchroniser fills.

Verification (SYNC_STAGES=2, TIMEOUT_CYCLES=16)
REQ-025 Basic transaction: hps_out=0x1_1234 with rx_ready=1 and tx_data=0xBEEF valid -> rx_valid at +3 cycles with rx_data=0x1234, then hps_in=0x1_BEEF; after hps_out[16]=0 -> ack=0 at +3 cycles and txn_count=1.
REQ-026 Backpressure: rx_ready=0 for 10 cycles -> rx_valid and rx_data stay stable; no timer advance.
REQ-027 Timeout: tx_valid never asserted -> 16 RESPOND cycles, then hps_in=0x1_FFFF and timeout_flag=1.
REQ-028 Coincidence: tx_valid on the 16th RESPOND cycle with 0x0042 -> hps_in=0x1_0042 and timeout_flag=0.
REQ-029 Abort and wrap: req dropped in RESPOND -> proto_err=1, IDLE, no ack; after preloading 0xFFFF transactions, one more -> txn_count=0x0000.
REQ-030 Reset mid-ACK -> hps_in=0 the same cycle and all sticky flags 0.
